// File: rtl/jzjpcc_rd_write_arbiter.sv
// Shares the register file write port between the writeback stage (always wins, zero latency)
// and a buffered auxiliary requester that drains into idle writeback slots.
module jzjpcc_rd_write_arbiter #(
    parameter int AUX_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [4:0]                     wbRdAddr_i,
    input  logic [31:0]                    wbRd_i,
    input  logic                           wbWriteEnable_i,
    input  logic                           auxValid_i,
    output logic                           auxReady_o,
    input  logic [4:0]                     auxRdAddr_i,
    input  logic [31:0]                    auxRd_i,
    output logic [4:0]                     rdAddr_o,
    output logic [31:0]                    rd_o,
    output logic                           rdWriteEnable_o,
    output logic                           stallRequest_o,
    input  logic [4:0]                     rs1Addr_i,
    input  logic [4:0]                     rs2Addr_i,
    output logic                           rs1Pending_o,
    output logic                           rs2Pending_o,
    output logic [$clog2(AUX_DEPTH+1)-1:0] auxCount_o
);

    localparam int PTR_W    = $clog2(AUX_DEPTH);
    localparam int CNT_W    = $clog2(AUX_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]          fifoAddr_q [AUX_DEPTH];
    logic [31:0]         fifoData_q [AUX_DEPTH];
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                stallRequest_q, stallRequest_d;

    logic                slotBusy;
    logic                fifoEmpty;
    logic                fifoFull;
    logic                pop;
    logic                push;
    logic                blocked;
    logic [AUX_DEPTH-1:0] entryValid;
    logic [PTR_W-1:0]    entryOffset;

    // auxReady depends only on registered occupancy (and reset), never on auxValid.
    always_comb begin
        slotBusy   = wbWriteEnable_i && (wbRdAddr_i != 5'd0);
        fifoEmpty  = (count_q == '0);
        fifoFull   = (count_q == CNT_W'(AUX_DEPTH));
        pop        = !slotBusy && !fifoEmpty;
        blocked    = slotBusy && !fifoEmpty;
        auxReady_o = rst_ni && !fifoFull;
        push       = auxValid_i && auxReady_o && (auxRdAddr_i != 5'd0);
    end

    always_comb begin
        rdWriteEnable_o = rst_ni && (slotBusy || !fifoEmpty);
        rdAddr_o        = slotBusy ? wbRdAddr_i : fifoAddr_q[rdPtr_q];
        rd_o            = slotBusy ? wbRd_i     : fifoData_q[rdPtr_q];
        stallRequest_o  = stallRequest_q;
        auxCount_o      = count_q;
    end

    always_comb begin
        rdPtr_d = pop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        wrPtr_d = push ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        starve_d = starve_q;
        if (pop || fifoEmpty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_W'(STARVE_LIMIT - 1)) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        // Once raised, the bubble request is held until the head entry actually drains.
        stallRequest_d = stallRequest_q;
        if (pop) begin
            stallRequest_d = 1'b0;
        end else if (blocked && (starve_q == STARVE_W'(STARVE_LIMIT - 1))) begin
            stallRequest_d = 1'b1;
        end
    end

    // An entry is live when its distance from the head (modulo depth) is below the occupancy.
    always_comb begin
        entryValid   = '0;
        entryOffset  = '0;
        rs1Pending_o = 1'b0;
        rs2Pending_o = 1'b0;
        for (int i = 0; i < AUX_DEPTH; i++) begin
            entryOffset   = PTR_W'(i) - rdPtr_q;
            entryValid[i] = (CNT_W'(entryOffset) < count_q);
            if (entryValid[i] && (rs1Addr_i != 5'd0) && (fifoAddr_q[i] == rs1Addr_i)) begin
                rs1Pending_o = 1'b1;
            end
            if (entryValid[i] && (rs2Addr_i != 5'd0) && (fifoAddr_q[i] == rs2Addr_i)) begin
                rs2Pending_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdPtr_q        <= '0;
            wrPtr_q        <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            stallRequest_q <= 1'b0;
        end else begin
            rdPtr_q        <= rdPtr_d;
            wrPtr_q        <= wrPtr_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            stallRequest_q <= stallRequest_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= auxRdAddr_i;
            fifoData_q[wrPtr_q] <= auxRd_i;
        end
    end

endmodule

// File: tb/tb_jzjpcc_rd_write_arbiter.sv
// Bench for jzjpcc_rd_write_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jzjpcc_rd_write_arbiter;

    localparam int AUX_DEPTH    = 2;
    localparam int STARVE_LIMIT = 8;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  wbRdAddr;
    logic [31:0] wbRd;
    logic        wbWriteEnable;
    logic        auxValid;
    logic        auxReady;
    logic [4:0]  auxRdAddr;
    logic [31:0] auxRd;
    logic [4:0]  rdAddr;
    logic [31:0] rd;
    logic        rdWriteEnable;
    logic        stallRequest;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic        rs1Pending;
    logic        rs2Pending;
    logic [$clog2(AUX_DEPTH+1)-1:0] auxCount;

    int checkCount = 0;
    int errorCount = 0;
    bit checkEnable = 0;

    entry_t modelQ[$];
    int     modelBlockedRun;
    bit     modelStall;

    jzjpcc_rd_write_arbiter #(
        .AUX_DEPTH   (AUX_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wbRdAddr_i     (wbRdAddr),
        .wbRd_i         (wbRd),
        .wbWriteEnable_i(wbWriteEnable),
        .auxValid_i     (auxValid),
        .auxReady_o     (auxReady),
        .auxRdAddr_i    (auxRdAddr),
        .auxRd_i        (auxRd),
        .rdAddr_o       (rdAddr),
        .rd_o           (rd),
        .rdWriteEnable_o(rdWriteEnable),
        .stallRequest_o (stallRequest),
        .rs1Addr_i      (rs1Addr),
        .rs2Addr_i      (rs2Addr),
        .rs1Pending_o   (rs1Pending),
        .rs2Pending_o   (rs2Pending),
        .auxCount_o     (auxCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad);
        wbWriteEnable = we;
        wbRdAddr      = wa;
        wbRd          = wd;
        auxValid      = av;
        auxRdAddr     = aa;
        auxRd         = ad;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pipeline pre-empts, queue drains in order, bubble after STARVE_LIMIT blocked cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modelQ.delete();
            modelBlockedRun = 0;
            modelStall      = 1'b0;
        end else begin
            automatic bit busy     = wbWriteEnable && (wbRdAddr != 5'd0);
            automatic bit hadItems = (modelQ.size() > 0);
            automatic bit accepted = auxValid && (modelQ.size() < AUX_DEPTH);
            if (!busy && hadItems) begin
                void'(modelQ.pop_front());
                modelBlockedRun = 0;
                modelStall      = 1'b0;
            end else if (hadItems) begin
                modelBlockedRun++;
                if (modelBlockedRun >= STARVE_LIMIT) modelStall = 1'b1;
            end else begin
                modelBlockedRun = 0;
            end
            if (accepted && (auxRdAddr != 5'd0)) begin
                modelQ.push_back('{addr: auxRdAddr, data: auxRd});
            end
        end
    end

    // Every cycle, away from the active edge, compare all outputs with the model.
    always @(negedge clk) begin
        if (checkEnable) begin
            if (!rst_n) begin
                checkOutput("cyc_rst_we", 32'(rdWriteEnable), 32'd0);
                checkOutput("cyc_rst_ready", 32'(auxReady), 32'd0);
                checkOutput("cyc_rst_count", 32'(auxCount), 32'd0);
                checkOutput("cyc_rst_stall", 32'(stallRequest), 32'd0);
            end else begin
                automatic bit busy  = wbWriteEnable && (wbRdAddr != 5'd0);
                automatic bit expWe = busy || (modelQ.size() > 0);
                automatic bit p1    = 1'b0;
                automatic bit p2    = 1'b0;
                foreach (modelQ[k]) begin
                    if (rs1Addr != 5'd0 && modelQ[k].addr == rs1Addr) p1 = 1'b1;
                    if (rs2Addr != 5'd0 && modelQ[k].addr == rs2Addr) p2 = 1'b1;
                end
                checkOutput("cyc_we", 32'(rdWriteEnable), 32'(expWe));
                if (busy) begin
                    checkOutput("cyc_addr_wb", 32'(rdAddr), 32'(wbRdAddr));
                    checkOutput("cyc_data_wb", rd, wbRd);
                end else if (modelQ.size() > 0) begin
                    checkOutput("cyc_addr_aux", 32'(rdAddr), 32'(modelQ[0].addr));
                    checkOutput("cyc_data_aux", rd, modelQ[0].data);
                end
                checkOutput("cyc_ready", 32'(auxReady), 32'(modelQ.size() < AUX_DEPTH));
                checkOutput("cyc_count", 32'(auxCount), 32'(modelQ.size()));
                checkOutput("cyc_stall", 32'(stallRequest), 32'(modelStall));
                checkOutput("cyc_rs1p", 32'(rs1Pending), 32'(p1));
                checkOutput("cyc_rs2p", 32'(rs2Pending), 32'(p2));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rs1Addr = 5'd0;
        rs2Addr = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkEnable = 1'b1;
        #2;
        checkOutput("rst_ready", 32'(auxReady), 32'd0);
        checkOutput("rst_we", 32'(rdWriteEnable), 32'd0);
        checkOutput("rst_count", 32'(auxCount), 32'd0);
        checkOutput("rst_stall", 32'(stallRequest), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready", 32'(auxReady), 32'd1);

        // Pipeline pass-through, and a write to x0 that frees the slot
        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        checkOutput("pass_we", 32'(rdWriteEnable), 32'd1);
        checkOutput("pass_addr", 32'(rdAddr), 32'd5);
        checkOutput("pass_data", rd, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1, 0, 32'h12345678, 0, 0, 0);
        #1;
        checkOutput("x0_wb_we", 32'(rdWriteEnable), 32'd0);

        // Aux drain in order, no bypass on enqueue
        nextCycle();
        applyStimulus(0, 0, 0, 1, 7, 32'h11);
        #1;
        checkOutput("drain_nobypass_we", 32'(rdWriteEnable), 32'd0);
        checkOutput("drain_count0", 32'(auxCount), 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 8, 32'h22);
        #1;
        checkOutput("drain1_we", 32'(rdWriteEnable), 32'd1);
        checkOutput("drain1_addr", 32'(rdAddr), 32'd7);
        checkOutput("drain1_data", rd, 32'h11);
        checkOutput("drain1_count", 32'(auxCount), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("drain2_addr", 32'(rdAddr), 32'd8);
        checkOutput("drain2_data", rd, 32'h22);
        checkOutput("drain2_count", 32'(auxCount), 32'd1);
        nextCycle();
        checkOutput("drain3_count", 32'(auxCount), 32'd0);
        checkOutput("drain3_we", 32'(rdWriteEnable), 32'd0);

        // Fill to capacity under a busy pipeline, then x0 handshake
        applyStimulus(1, 10, 32'hA, 1, 3, 32'h33);
        nextCycle();
        applyStimulus(1, 11, 32'hB, 1, 4, 32'h44);
        #1;
        checkOutput("fill_count1", 32'(auxCount), 32'd1);
        nextCycle();
        applyStimulus(1, 12, 32'hC, 1, 5, 32'h55);
        rs1Addr = 5'd4;
        rs2Addr = 5'd3;
        #1;
        checkOutput("full_ready", 32'(auxReady), 32'd0);
        checkOutput("full_count", 32'(auxCount), 32'd2);
        checkOutput("full_rs1p", 32'(rs1Pending), 32'd1);
        checkOutput("full_rs2p", 32'(rs2Pending), 32'd1);
        checkOutput("full_wbwins", 32'(rdAddr), 32'd12);
        nextCycle();
        checkOutput("full_hold_count", 32'(auxCount), 32'd2);
        applyStimulus(0, 0, 0, 1, 5, 32'h55);
        #1;
        checkOutput("fullpop_ready", 32'(auxReady), 32'd0);
        checkOutput("fullpop_addr", 32'(rdAddr), 32'd3);
        checkOutput("fullpop_data", rd, 32'h33);
        nextCycle();
        applyStimulus(1, 13, 32'hD, 1, 0, 32'h99);
        #1;
        checkOutput("x0_ready", 32'(auxReady), 32'd1);
        checkOutput("x0_count_before", 32'(auxCount), 32'd1);
        checkOutput("x0_rs2p", 32'(rs2Pending), 32'd0);
        checkOutput("x0_rs1p", 32'(rs1Pending), 32'd1);
        nextCycle();
        applyStimulus(1, 14, 32'hE, 1, 5, 32'h55);
        #1;
        checkOutput("x0_count_after", 32'(auxCount), 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("fd1_count", 32'(auxCount), 32'd2);
        checkOutput("fd1_addr", 32'(rdAddr), 32'd4);
        checkOutput("fd1_data", rd, 32'h44);
        nextCycle();
        checkOutput("fd2_addr", 32'(rdAddr), 32'd5);
        checkOutput("fd2_data", rd, 32'h55);
        checkOutput("fd2_rs1p", 32'(rs1Pending), 32'd0);
        nextCycle();
        checkOutput("fd3_count", 32'(auxCount), 32'd0);
        rs1Addr = 5'd0;
        rs2Addr = 5'd0;

        // Starvation: one entry, pipeline busy every cycle, then contract violation and bubble
        applyStimulus(0, 0, 0, 1, 20, 32'h2020);
        nextCycle();
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            applyStimulus(1, 5'(21 + k), 32'(k), 0, 0, 0);
            #1;
            checkOutput("starve_low", 32'(stallRequest), 32'd0);
            nextCycle();
        end
        applyStimulus(1, 9, 32'h9999, 0, 0, 0);
        #1;
        checkOutput("starve_high", 32'(stallRequest), 32'd1);
        checkOutput("viol_addr", 32'(rdAddr), 32'd9);
        checkOutput("viol_data", rd, 32'h9999);
        checkOutput("viol_count", 32'(auxCount), 32'd1);
        nextCycle();
        checkOutput("viol_stall_hold", 32'(stallRequest), 32'd1);
        checkOutput("viol_count_hold", 32'(auxCount), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("bubble_we", 32'(rdWriteEnable), 32'd1);
        checkOutput("bubble_addr", 32'(rdAddr), 32'd20);
        checkOutput("bubble_data", rd, 32'h2020);
        checkOutput("bubble_stall", 32'(stallRequest), 32'd1);
        nextCycle();
        checkOutput("after_bubble_stall", 32'(stallRequest), 32'd0);
        checkOutput("after_bubble_count", 32'(auxCount), 32'd0);

        // Reset in the middle of traffic with two queued entries
        applyStimulus(1, 15, 32'hF, 1, 6, 32'h66);
        nextCycle();
        applyStimulus(1, 16, 32'hF0, 1, 7, 32'h77);
        nextCycle();
        checkOutput("pre_rst_count", 32'(auxCount), 32'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_count", 32'(auxCount), 32'd0);
        checkOutput("mid_rst_ready", 32'(auxReady), 32'd0);
        checkOutput("mid_rst_we", 32'(rdWriteEnable), 32'd0);
        checkOutput("mid_rst_stall", 32'(stallRequest), 32'd0);
        applyStimulus(1, 16, 32'hF0, 0, 0, 0);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(auxReady), 32'd1);
        checkOutput("post_rst_count", 32'(auxCount), 32'd0);
        checkOutput("post_rst_addr", 32'(rdAddr), 32'd16);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("post_rst_discard", 32'(rdWriteEnable), 32'd0);
        nextCycle();
        nextCycle();

        checkEnable = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/jzjpcc_rd_write_arbiter.md
# jzjpcc_rd_write_arbiter

Shares the register file's single write port between the pipeline writeback stage (outputs of jzjpcc_writeback) and an auxiliary multi-cycle requester (e.g. multiply/divide unit). Pipeline writes pass through with zero latency and always have priority. Auxiliary writes are buffered in a small FIFO and drain into idle writeback slots. A starvation guard requests a pipeline bubble so buffered writes always complete, and pending-address lookups let decode stall on registers with queued writes.

## Interface
Parameters:
- AUX_DEPTH, 2: auxiliary FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8: consecutive blocked cycles before a bubble is requested; ≥1

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wbRdAddr  input  5  destination from writeback stage
- wbRd  input  32  write data from writeback stage
- wbWriteEnable  input  1  writeback stage write request
- auxValid  input  1  auxiliary write request valid
- auxReady  output  1  auxiliary request accepted when auxValid & auxReady
- auxRdAddr  input  5  auxiliary destination register
- auxRd  input  32  auxiliary write data
- rdAddr  output  5  register file write address
- rd  output  32  register file write data
- rdWriteEnable  output  1  register file write strobe
- stallRequest  output  1  registered; requests a writeback bubble
- rs1Addr, rs2Addr  input  5 each  decode source registers
- rs1Pending, rs2Pending  output  1 each  source has a queued auxiliary write
- auxCount  output  $clog2(AUX_DEPTH+1)  occupied FIFO entries

## Operation
- Slot busy = wbWriteEnable && wbRdAddr != 0; otherwise slot free.
- Slot busy: rdAddr/rd = wb inputs, rdWriteEnable = 1; FIFO untouched.
- Slot free and FIFO non-empty: output head entry, rdWriteEnable = 1, pop.
- Slot free and FIFO empty: rdWriteEnable = 0; rdAddr/rd don't-care.
- auxReady = !full; derived from registered state only, never from auxValid.
- Handshake with auxRdAddr == 0: completes, nothing stored.
- Handshake with nonzero address: enqueue at tail; FIFO order preserved.
- Full with pop in same cycle: auxReady still 0 (no simultaneous enqueue at full).
- Empty with enqueue: no bypass; entry drains at earliest next cycle.
- Starvation counter: increments each cycle FIFO non-empty and no pop; clears on pop or when empty.
- Blocked cycle with counter == STARVE_LIMIT-1: stallRequest <= 1.
- stallRequest holds 1 until a pop; clears on the edge after the pop.
- Upstream contract: stallRequest == 1 forces slot free. If violated, pipeline still wins; no data lost.
- rsXPending = rsXAddr != 0 && matches any valid FIFO entry address. Aux unit keeps its own busy flag through the handshake cycle.
- Same-rd ordering (aux queued, newer pipeline write to same rd) is excluded by decode stalling on rsXPending/rd scoreboard; not arbitrated here.
- While reset low: FIFO pointers/count, counter, stallRequest all 0; auxReady = 0; rdWriteEnable = 0.
- Reset mid-operation discards queued entries.

## Timing
- Pipeline path: combinational, 0 cycles wb inputs -> rd outputs.
- Aux path: handshake at edge N; earliest register file write in cycle N+1.
- Drain throughput: one entry per free slot.
- Starvation: head drainable from cycle T, blocked T..T+STARVE_LIMIT-1 -> stallRequest = 1 in cycle T+STARVE_LIMIT.
- Bubble honored: pop in cycle T+STARVE_LIMIT; stallRequest = 0 from T+STARVE_LIMIT+1.
- auxCount and rsXPending reflect registered FIFO state; they update on the edge after enqueue/pop.

## Test plan
- Reset: assert reset low mid-traffic with 2 queued entries -> auxCount = 0, auxReady = 0, rdWriteEnable = 0, stallRequest = 0; after release auxReady = 1.
- Pass-through: wbWriteEnable = 1, wbRdAddr = 5, wbRd = 0xDEADBEEF -> same-cycle rdWriteEnable = 1, rdAddr = 5, rd = 0xDEADBEEF.
- Aux drain: pipeline idle, aux writes x7 = 0x11 then x8 = 0x22 back-to-back -> writes x7 then x8 in consecutive cycles, order preserved; auxCount 1, 1, 0.
- Full/x0: AUX_DEPTH = 2, pipeline busy, aux sends x3, x4, x5 -> x5 stalls with auxReady = 0 and rs1Pending = 1 for rs1Addr = 4; aux write to x0 handshakes, auxCount unchanged.
- Starvation: STARVE_LIMIT = 8, one entry queued, pipeline busy every cycle -> stallRequest = 1 exactly 8 cycles after entry drainable. Bench gives bubble -> entry written, stallRequest = 0 next cycle.
- Contract violation: stallRequest = 1 while pipeline writes x9 -> x9 written, aux entry retained, stallRequest stays 1.
